semaforo_n_vias: RTL and testbench
==================================

// Module: semaforo_n_vias
// PURPOSE
//  Sequential traffic-light controller for N_VIAS converging roads, one vehicle sensor each.
//  Grants green to one road at a time with timed minimum green, yellow and all-red clearance.
//  Next road chosen by fixed priority (lowest index wins) or round-robin, selected at run time.
//  Road 0 is the default road: it holds green whenever there is no demand.
// PARAMETERS
//  N_VIAS     3  number of roads (>=2)
//  T_VERDE    8  minimum green time, clock cycles (>=1)
//  T_AMARELO  3  yellow time, clock cycles (>=1)
//  T_LIMPEZA  1  all-red clearance time, clock cycles (>=1)
// PORTS
//  clk       in   1       system clock, rising edge
//  reset     in   1       asynchronous, active-high reset
//  sensores  in   N_VIAS  bit i = vehicle waiting on road i (synchronous to clk)
//  modo      in   1       0 = fixed priority, 1 = round-robin; sampled only when choosing next road
//  verde     out  N_VIAS  one-hot green lamps
//  amarelo   out  N_VIAS  yellow lamps, at most one bit set
//  vermelho  out  N_VIAS  red lamps; for every road exactly one of verde/amarelo/vermelho is set
//  via_atual out  $clog2(N_VIAS)  index of the road owning green/yellow
//  troca     out  1       one-cycle pulse on the first cycle of a new road's green
// BEHAVIOUR
//  Reset (async, immediate): estado=VERDE, via_atual=0, cnt=0, proxima=0, troca=0.
//   Outputs: verde=...001, amarelo=0, vermelho=~...001.
//  Outputs are a pure decode of registered state (Moore); they change only on clk edges or reset.
//  FSM states and transitions:
//   VERDE: cnt counts up, saturating at T_VERDE-1.
//    Once cnt==T_VERDE-1, decision evaluated every cycle:
//     a) some road j!=via_atual has sensores[j]=1 -> proxima=select(), go AMARELO, cnt=0.
//     b) no demand at all and via_atual!=0 -> proxima=0, go AMARELO.
//     c) otherwise stay in VERDE (green extended indefinitely).
//    The sensor of the current road never causes or blocks a change.
//   AMARELO: amarelo[via_atual]=1 for exactly T_AMARELO cycles, then LIMPEZA, cnt=0.
//   LIMPEZA: all outputs red for exactly T_LIMPEZA cycles, then VERDE.
//    On that edge: via_atual=proxima, cnt=0, troca=1 for one cycle.
//  select(): chooses among requesters excluding via_atual.
//   modo=0: lowest index.
//   modo=1: first requester scanning via_atual+1, via_atual+2, ..., wrapping modulo N_VIAS.
//  proxima is latched on entry to AMARELO; sensor or modo changes afterwards do not alter the target.
//  A new green therefore lasts >= T_VERDE cycles.
//  Full change cycle (last green -> new green) = T_AMARELO + T_LIMPEZA cycles of non-green for the old road.
//  cnt width = $clog2(max(T_VERDE,T_AMARELO,T_LIMPEZA)+1); counter never wraps.
//  Reset mid-operation (any state) -> reset values immediately, no pending target retained.
// TESTING  (N_VIAS=3, T_VERDE=4, T_AMARELO=2, T_LIMPEZA=1; cycle 0 = first edge after reset release)
//  1. Idle default: sensores=000 for 30 cycles.
//     -> verde=001, vermelho=110, amarelo=000 throughout; troca never pulses.
//  2. Single request: sensores=100 from cycle 0.
//     -> verde=001 cycles 0-3; amarelo=001 cycles 4-5; all red cycle 6.
//     -> verde=100, via_atual=2, troca=1 at cycle 7.
//  3. Fixed priority: modo=0, road 0 green, sensores=110.
//     -> next green road 1.
//     -> with sensores still 110 after its min green, next road 2.
//  4. Round-robin wrap: modo=1, road 2 green, sensores=011.
//     -> next road 0; then road 1.
//     Return to default: road 1 green, sensores=000 -> returns to road 0.
//  5. Latched target: request on road 1 drops to 0 during AMARELO, modo toggled.
//     -> green still granted to road 1.
//     Current road's own sensor=1 with no others -> stays green.
//  6. Async reset asserted mid-AMARELO, between clock edges.
//     -> outputs go to verde=001, amarelo=000 without a clock edge; troca=0.

Source files
------------

// File: rtl/semaforo_n_vias_if.sv
// Lamp/sensor bundle of the N-road traffic-light controller.
interface semaforo_n_vias_if #(
   parameter int unsigned N_VIAS = 3
);
   localparam int unsigned W_VIA = (N_VIAS > 1) ? $clog2(N_VIAS) : 1;

   logic [N_VIAS-1:0] sensores;
   logic              modo;
   logic [N_VIAS-1:0] verde;
   logic [N_VIAS-1:0] amarelo;
   logic [N_VIAS-1:0] vermelho;
   logic [W_VIA-1:0]  via_atual;
   logic              troca;

   modport master (
      output sensores, modo,
      input  verde, amarelo, vermelho, via_atual, troca
   );

   modport slave (
      input  sensores, modo,
      output verde, amarelo, vermelho, via_atual, troca
   );
endinterface

// File: rtl/semaforo_n_vias.sv
// Traffic-light controller for N converging roads: timed green/yellow/all-red
// cycle, next road picked by fixed priority or round-robin, road 0 is default.
module semaforo_n_vias #(
   parameter int unsigned N_VIAS    = 3,
   parameter int unsigned T_VERDE   = 8,
   parameter int unsigned T_AMARELO = 3,
   parameter int unsigned T_LIMPEZA = 1
) (
   input logic              clk,
   input logic              reset,
   semaforo_n_vias_if.slave bus
);
   localparam int unsigned W_VIA = (N_VIAS > 1) ? $clog2(N_VIAS) : 1;
   localparam int unsigned T_MAX_VA = (T_VERDE > T_AMARELO) ? T_VERDE : T_AMARELO;
   localparam int unsigned T_MAX = (T_MAX_VA > T_LIMPEZA) ? T_MAX_VA : T_LIMPEZA;
   localparam int unsigned W_CNT = $clog2(T_MAX + 1);

   typedef enum logic [1:0] {VERDE, AMARELO, LIMPEZA} estado_t;

   estado_t           estado, estado_n;
   logic [W_CNT-1:0]  cnt, cnt_n;
   logic [W_VIA-1:0]  via, via_n;
   logic [W_VIA-1:0]  proxima, proxima_n;
   logic              troca_q, troca_n;
   logic [N_VIAS-1:0] verde_q, verde_n;
   logic [N_VIAS-1:0] amarelo_q, amarelo_n;
   logic [N_VIAS-1:0] vermelho_q, vermelho_n;

   logic [N_VIAS-1:0] outros;
   logic [W_VIA-1:0]  sel;
   logic              achou;

   // Choose the next road among requesters other than the current one.
   always_comb begin
      outros      = bus.sensores;
      outros[via] = 1'b0;
      sel         = '0;
      achou       = 1'b0;
      if (!bus.modo) begin
         for (int unsigned i = 0; i < N_VIAS; i++) begin
            if (outros[i] && !achou) begin
               sel   = W_VIA'(i);
               achou = 1'b1;
            end
         end
      end else begin
         for (int unsigned k = 1; k < N_VIAS; k++) begin
            if (outros[(32'(via) + k) % N_VIAS] && !achou) begin
               sel   = W_VIA'((32'(via) + k) % N_VIAS);
               achou = 1'b1;
            end
         end
      end
   end

   // Next state plus lamp decode of the next state, so lamps leave a flop.
   always_comb begin
      estado_n   = estado;
      cnt_n      = cnt;
      via_n      = via;
      proxima_n  = proxima;
      troca_n    = 1'b0;
      verde_n    = '0;
      amarelo_n  = '0;
      vermelho_n = '1;

      case (estado)
         VERDE: begin
            if (cnt != W_CNT'(T_VERDE - 1)) begin
               cnt_n = cnt + W_CNT'(1);
            end else if (outros != '0) begin
               proxima_n = sel;
               estado_n  = AMARELO;
               cnt_n     = '0;
            end else if (bus.sensores == '0 && via != '0) begin
               proxima_n = '0;
               estado_n  = AMARELO;
               cnt_n     = '0;
            end
         end
         AMARELO: begin
            if (cnt == W_CNT'(T_AMARELO - 1)) begin
               estado_n = LIMPEZA;
               cnt_n    = '0;
            end else begin
               cnt_n = cnt + W_CNT'(1);
            end
         end
         LIMPEZA: begin
            if (cnt == W_CNT'(T_LIMPEZA - 1)) begin
               estado_n = VERDE;
               via_n    = proxima;
               cnt_n    = '0;
               troca_n  = 1'b1;
            end else begin
               cnt_n = cnt + W_CNT'(1);
            end
         end
         default: begin
            estado_n = VERDE;
            cnt_n    = '0;
            via_n    = '0;
         end
      endcase

      case (estado_n)
         VERDE: begin
            verde_n[via_n]    = 1'b1;
            vermelho_n[via_n] = 1'b0;
         end
         AMARELO: begin
            amarelo_n[via_n]  = 1'b1;
            vermelho_n[via_n] = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado     <= VERDE;
         cnt        <= '0;
         via        <= '0;
         proxima    <= '0;
         troca_q    <= 1'b0;
         verde_q    <= N_VIAS'(1);
         amarelo_q  <= '0;
         vermelho_q <= ~N_VIAS'(1);
      end else begin
         estado     <= estado_n;
         cnt        <= cnt_n;
         via        <= via_n;
         proxima    <= proxima_n;
         troca_q    <= troca_n;
         verde_q    <= verde_n;
         amarelo_q  <= amarelo_n;
         vermelho_q <= vermelho_n;
      end
   end

   assign bus.verde     = verde_q;
   assign bus.amarelo   = amarelo_q;
   assign bus.vermelho  = vermelho_q;
   assign bus.via_atual = via;
   assign bus.troca     = troca_q;
endmodule

// File: tb/tb_semaforo_n_vias.sv
// Self-checking bench for semaforo_n_vias: directed scenarios then random
// sensor/modo traffic, compared every cycle against a timeline reference model.
module tb_semaforo_n_vias;
   localparam int unsigned N  = 3;
   localparam int unsigned TV = 4;
   localparam int unsigned TA = 2;
   localparam int unsigned TL = 1;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   semaforo_n_vias_if #(.N_VIAS(N)) bus ();

   semaforo_n_vias #(
      .N_VIAS(N), .T_VERDE(TV), .T_AMARELO(TA), .T_LIMPEZA(TL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: road owning the lamps, cycles it has been green, non-green
   // cycles still to run (yellow while above TL, red otherwise), chosen target.
   int m_road, m_age, m_ng, m_target;
   bit m_troca;

   task automatic model_reset();
      m_road = 0; m_age = 0; m_ng = 0; m_target = 0; m_troca = 0;
   endtask

   function automatic int pick(input logic [N-1:0] others, input logic m);
      if (!m) begin
         for (int j = 0; j < int'(N); j++) if (others[j]) return j;
      end else begin
         for (int k = 1; k < int'(N); k++) if (others[(m_road + k) % N]) return (m_road + k) % N;
      end
      return 0;
   endfunction

   task automatic model_step(input logic [N-1:0] s, input logic m);
      logic [N-1:0] others;
      if (m_ng > 0) begin
         m_troca = 0;
         m_ng--;
         if (m_ng == 0) begin
            m_road  = m_target;
            m_age   = 0;
            m_troca = 1;
         end
      end else begin
         m_troca = 0;
         if (m_age >= int'(TV) - 1) begin
            others = s & ~(N'(1) << m_road);
            if (others != '0) begin
               m_target = pick(others, m);
               m_ng     = TA + TL;
            end else if (s == '0 && m_road != 0) begin
               m_target = 0;
               m_ng     = TA + TL;
            end
         end
         if (m_age < int'(TV)) m_age++;
      end
   endtask

   task automatic check(input string tag);
      logic [N-1:0] v, a, r;
      logic [3*N+2:0] obs, exp;
      v = '0; a = '0; r = '1;
      if (m_ng == 0) begin
         v[m_road] = 1'b1; r[m_road] = 1'b0;
      end else if (m_ng > int'(TL)) begin
         a[m_road] = 1'b1; r[m_road] = 1'b0;
      end
      exp = {v, a, r, 2'(m_road), m_troca};
      obs = {bus.verde, bus.amarelo, bus.vermelho, bus.via_atual, bus.troca};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the model in step.
   task automatic tick(input logic [N-1:0] s, input logic m, input string tag);
      bus.sensores = s;
      bus.modo     = m;
      model_step(s, m);
      @(posedge clk);
      @(negedge clk);
      check(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1 check("reset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_release");
   endtask

   task automatic wait_troca(input logic [N-1:0] s, input logic m, input int road, input string tag);
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(s, m, tag);
         seen = bus.troca;
      end
      check_val({tag, "_road"}, seen ? 8'(bus.via_atual) : 8'hff, 8'(road));
   endtask

   task automatic wait_amarelo(input logic [N-1:0] s, input logic m, input string tag);
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick(s, m, tag);
         seen = (bus.amarelo != '0);
      end
      check_val({tag, "_reached"}, 8'(seen), 8'd1);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      clk = 1'b0; reset = 1'b1;
      bus.sensores = '0; bus.modo = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Idle: default road holds green.
      for (int i = 0; i < 30; i++) tick(3'b000, 1'b0, "idle");
      check_val("idle_verde", 8'(bus.verde), 8'h01);

      // Single request on road 2 with exact timing.
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         tick(3'b100, 1'b0, "single");
         if (i == 4) check_val("single_amarelo_c4", 8'(bus.amarelo), 8'h01);
         if (i == 6) check_val("single_allred_c6", 8'(bus.vermelho), 8'h07);
      end
      check_val("single_verde_c7", 8'(bus.verde), 8'h04);
      check_val("single_via_c7", 8'(bus.via_atual), 8'd2);
      check_val("single_troca_c7", 8'(bus.troca), 8'd1);

      // Fixed priority, then round-robin wrap, then return to default.
      do_reset();
      wait_troca(3'b110, 1'b0, 1, "prio_first");
      wait_troca(3'b110, 1'b0, 2, "prio_second");
      wait_troca(3'b011, 1'b1, 0, "rr_wrap");
      wait_troca(3'b011, 1'b1, 1, "rr_next");
      wait_troca(3'b000, 1'b1, 0, "default_return");

      // Target latched on entry to yellow despite request and modo changes.
      wait_amarelo(3'b010, 1'b0, "latch_enter");
      wait_troca(3'b000, 1'b1, 1, "latch_target");
      for (int i = 0; i < 15; i++) tick(3'b010, 1'b0, "own_sensor");
      check_val("own_sensor_verde", 8'(bus.verde), 8'h02);

      // Async reset in the middle of yellow, between edges.
      do_reset();
      wait_amarelo(3'b100, 1'b0, "async_enter");
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_val("async_verde", 8'(bus.verde), 8'h01);
      check_val("async_amarelo", 8'(bus.amarelo), 8'h00);
      check_val("async_troca", 8'(bus.troca), 8'h00);
      check("async_all");
      @(negedge clk);
      reset = 1'b0;
      check("async_release");

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            logic [N-1:0] s;
            s = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            tick(s, 1'($urandom), "random");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
